// File: rtl/alu_batch_scheduler_if.sv
// Operand-memory read port and ALU start/done handshake seen by the batch scheduler.
interface alu_batch_scheduler_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0]        mem_addr;
    logic [31:0]              mem_rdata;
    logic [1:0]               alu_op;
    logic signed [DATA_W-1:0] alu_a;
    logic signed [DATA_W-1:0] alu_b;
    logic                     alu_start;
    logic                     alu_done;
    logic signed [DATA_W-1:0] alu_result;
    logic                     alu_ovf;
    logic                     alu_unf;

    modport master (
        output mem_addr, alu_op, alu_a, alu_b, alu_start,
        input  mem_rdata, alu_done, alu_result, alu_ovf, alu_unf
    );

    modport slave (
        input  mem_addr, alu_op, alu_a, alu_b, alu_start,
        output mem_rdata, alu_done, alu_result, alu_ovf, alu_unf
    );
endinterface

// File: rtl/alu_batch_scheduler.sv
// Walks operand memory from first to last address, issues each word to the ALU and strobes results.
// Optional ALU_TIMEOUT_EN: abandon an entry with error status after TIMEOUT cycles without alu_done.
module alu_batch_scheduler #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [ADDR_W-1:0]        i_first_addr,
    input  logic [ADDR_W-1:0]        i_last_addr,
    alu_batch_scheduler_if.master    bus,
    output logic                     o_res_valid,
    output logic [ADDR_W-1:0]        o_res_addr,
    output logic signed [DATA_W-1:0] o_res_data,
    output logic [1:0]               o_res_status,
    output logic                     o_busy,
    output logic                     o_batch_done,
    output logic [ADDR_W:0]          o_err_count
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT_MEM, S_ISSUE, S_WAIT_ALU, S_WRITE, S_NEXT, S_FINISH
    } state_t;

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_OVF = 2'd1;
    localparam logic [1:0] ST_UNF = 2'd2;
    localparam logic [1:0] ST_ERR = 2'd3;

    state_t                   r_state;
    state_t                   w_next;
    logic [ADDR_W-1:0]        r_cur;
    logic [ADDR_W-1:0]        r_end;
    logic [3:0]               r_op;
    logic signed [DATA_W-1:0] r_a;
    logic signed [DATA_W-1:0] r_b;
    logic signed [DATA_W-1:0] r_res;
    logic [1:0]               r_status;
    logic [ADDR_W:0]          r_err;
    logic                     r_abort;
    logic                     w_bad_op;
    logic                     w_tmo;
    logic                     w_unused_bits;

    function automatic logic [1:0] f_status(input logic ovf, input logic unf);
        if (ovf) return ST_OVF;
        if (unf) return ST_UNF;
        return ST_OK;
    endfunction

`ifdef ALU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo;

    always_ff @(posedge clk) begin
        if (!rst || r_state != S_WAIT_ALU) r_tmo <= '0;
        else                              r_tmo <= r_tmo + 1'b1;
    end

    assign w_tmo = (r_state == S_WAIT_ALU) && !bus.alu_done && (r_tmo == TMO_W'(TIMEOUT - 1));
`else
    assign w_tmo = 1'b0;
`endif

    assign w_unused_bits = ^{bus.mem_rdata[31:24], bus.mem_rdata[7:4], (TIMEOUT > 0)};
    assign w_bad_op      = (r_op > 4'd3);

    assign bus.mem_addr = r_cur;
    assign bus.alu_op   = r_op[1:0];
    assign bus.alu_a    = r_a;
    assign bus.alu_b    = r_b;
    assign o_res_addr   = r_cur;
    assign o_res_data   = r_res;
    assign o_res_status = r_status;
    assign o_err_count  = r_err;

    always_comb begin
        w_next        = r_state;
        bus.alu_start = 1'b0;
        o_res_valid   = 1'b0;
        o_batch_done  = 1'b0;
        o_busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = S_FETCH;
            end
            S_FETCH:    w_next = S_WAIT_MEM;
            S_WAIT_MEM: w_next = S_ISSUE;
            S_ISSUE: begin
                bus.alu_start = !w_bad_op;
                w_next        = w_bad_op ? S_WRITE : S_WAIT_ALU;
            end
            S_WAIT_ALU: if (bus.alu_done || w_tmo) w_next = S_WRITE;
            S_WRITE: begin
                o_res_valid = 1'b1;
                w_next      = S_NEXT;
            end
            S_NEXT: w_next = (r_abort || i_abort || r_cur == r_end) ? S_FINISH : S_FETCH;
            S_FINISH: begin
                o_busy       = 1'b0;
                o_batch_done = 1'b1;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cur    <= '0;
            r_end    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_status <= ST_OK;
            r_err    <= '0;
            r_abort  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_cur <= i_first_addr;
                    r_end <= i_last_addr;
                    r_err <= '0;
                end
                S_WAIT_MEM: begin
                    r_op <= bus.mem_rdata[3:0];
                    r_a  <= $signed(bus.mem_rdata[8 +: DATA_W]);
                    r_b  <= $signed(bus.mem_rdata[16 +: DATA_W]);
                end
                S_ISSUE: if (w_bad_op) begin
                    r_res    <= '0;
                    r_status <= ST_ERR;
                end
                S_WAIT_ALU: if (bus.alu_done) begin
                    r_res    <= bus.alu_result;
                    r_status <= f_status(bus.alu_ovf, bus.alu_unf);
                end else if (w_tmo) begin
                    r_res    <= '0;
                    r_status <= ST_ERR;
                end
                S_WRITE: if (r_status == ST_ERR) r_err <= r_err + 1'b1;
                S_NEXT:  if (w_next == S_FETCH) r_cur <= r_cur + 1'b1;
                default: ;
            endcase
            // Abort is only meaningful inside a batch; an abort coincident with start is dropped.
            if (r_state == S_IDLE || r_state == S_FINISH) r_abort <= 1'b0;
            else if (i_abort)                             r_abort <= 1'b1;
        end
    end
endmodule
